// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: the clear-sequencer
// state encoding and the default data/address widths.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clrState_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer for the register file. Walks an index over every entry,
// one per cycle, while asserting a write-enable so the storage zeroes that
// entry. Entered on reset or on a clear request; requests made while a clear
// is already running are ignored.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    clrState_e         state_q, state_d;
    logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;

    // State and index registers; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
        end
    end

    // Next-state logic: leave CLEAR on the cycle after the last entry is zeroed.
    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d  = CLEAR;
                    clrIdx_d = '0;
                end
            end
            CLEAR: begin
                if (&clrIdx_q) begin
                    state_d  = IDLE;
                    clrIdx_d = '0;
                end else begin
                    clrIdx_d = clrIdx_q + 1'b1;
                end
            end
            default: begin
                state_d  = CLEAR;
                clrIdx_d = '0;
            end
        endcase
    end

    assign busy    = (state_q == CLEAR);
    assign clr_we  = (state_q == CLEAR);
    assign clr_idx = clrIdx_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with one write port, two combinational read
// ports and a sequential clear. Entry 0 may be hardwired to zero (ZERO_REG).
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write that
// commits this cycle is forwarded to any read port addressing the same entry.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              clear_req,
    output logic              busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              clrWe;
    logic [ADDR_W-1:0] clrIdx;
    logic              wrCommit;
    logic              wrStore;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clrSeq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clrWe),
        .clr_idx   (clrIdx)
    );

    // A write commits only when the clear is idle and reset is not overriding it;
    // writes to a hardwired-zero entry 0 commit but never reach storage.
    assign wr_ready = ~busy;
    assign wrCommit = wr_en & wr_ready & ~rst;
    assign wrStore  = wrCommit & ~(ZERO_EN && (wr_addr == '0));

    // Storage update: the clear sequence owns the array while it runs.
    always_ff @(posedge clk) begin
        if (clrWe) begin
            mem_q[clrIdx] <= '0;
        end else if (wrStore) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port 1: optional same-cycle forwarding, then zero forcing while busy or for entry 0.
    always_comb begin
        rd_data1 = mem_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wrCommit && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
`endif
        if (busy || (ZERO_EN && (rd_addr1 == '0))) begin
            rd_data1 = '0;
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        rd_data2 = mem_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wrCommit && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_data;
        end
`endif
        if (busy || (ZERO_EN && (rd_addr2 == '0))) begin
            rd_data2 = '0;
        end
    end

endmodule
